// File: rtl/esfa_vector_sequencer_if.sv
// ROM read port and DUT operation/result bus of the ESFA vector sequencer.
interface esfa_vector_sequencer_if #(
  parameter int VAL_W  = 8,
  parameter int ADDR_W = 32
);
  localparam int VEC_W = 8 + 5 * VAL_W;

  logic [ADDR_W-1:0] rom_addr;
  logic [VEC_W-1:0]  rom_data;
  logic              dut_valid;
  logic [VAL_W-1:0]  dut_handle;
  logic [VAL_W-1:0]  dut_index;
  logic [VAL_W-1:0]  dut_value;
  logic [VAL_W-1:0]  dut_selector;
  logic              dut_result_bool;
  logic [VAL_W-1:0]  dut_result_value;

  modport master (
    output rom_addr, dut_valid, dut_handle, dut_index, dut_value, dut_selector,
    input  rom_data, dut_result_bool, dut_result_value
  );

  modport slave (
    input  rom_addr, dut_valid, dut_handle, dut_index, dut_value, dut_selector,
    output rom_data, dut_result_bool, dut_result_value
  );
endinterface

// File: rtl/esfa_vector_sequencer.sv
// ESFA vector sequencer: walks a vector ROM, issues one DUT operation per
// vector, checks non-mutating results and reports pass/error count/first fail.
module esfa_vector_sequencer #(
  parameter int VAL_W       = 8,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 8,
  parameter int ROM_LAT     = 1,
  parameter int DUT_LAT     = 1,
  parameter int ERR_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop_on_fail,
  esfa_vector_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  overrun,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_fail_addr
);
  localparam int VEC_W = 8 + 5 * VAL_W;
  localparam logic [3:0] ROM_LAST = 4'(ROM_LAT - 1);
  localparam logic [3:0] DUT_LAST = 4'(DUT_LAT - 1);
  localparam logic [ADDR_W:0] STRIDE_X = (ADDR_W + 1)'(ADDR_STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;
  state_t state, nextState;

  logic [3:0]       cnt;
  logic             mutReg, expBoolReg;
  logic [VEC_W-9:0] opReg;
  logic [VAL_W-1:0] expVal;
  logic             romEnd, fetchLast, waitLast, mismatch, stopNow, addrWrap;
  logic [ADDR_W:0]  addrSum;
  logic             unusedRomBits;

  // operand fields are held in opReg from the FETCH latch until the next one
  assign bus.dut_handle   = opReg[0 +: VAL_W];
  assign bus.dut_index    = opReg[VAL_W +: VAL_W];
  assign bus.dut_value    = opReg[2*VAL_W +: VAL_W];
  assign bus.dut_selector = opReg[3*VAL_W +: VAL_W];
  assign expVal           = opReg[4*VAL_W +: VAL_W];

  assign romEnd        = bus.rom_data[2];
  assign unusedRomBits = ^bus.rom_data[7:3];
  assign fetchLast     = (cnt == ROM_LAST);
  assign waitLast      = (cnt == DUT_LAST);
  assign mismatch      = !mutReg && ((bus.dut_result_bool != expBoolReg) ||
                                     (bus.dut_result_value != expVal));
  assign stopNow       = mismatch && stop_on_fail;
  // carry out of the extended sum means the next address would wrap
  assign addrSum       = {1'b0, bus.rom_addr} + STRIDE_X;
  assign addrWrap      = addrSum[ADDR_W];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  // next-state and state-decoded outputs
  always_comb begin
    nextState     = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.dut_valid = 1'b0;
    case (state)
      S_IDLE:  if (start) nextState = S_FETCH;
      S_FETCH: begin
        busy = 1'b1;
        if (fetchLast) nextState = romEnd ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy          = 1'b1;
        bus.dut_valid = 1'b1;
        nextState     = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (waitLast) nextState = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        nextState = (stopNow || addrWrap) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) nextState = S_FETCH;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // datapath: latency counter, vector latch, address walk and result tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      mutReg          <= 1'b0;
      expBoolReg      <= 1'b0;
      opReg           <= '0;
      bus.rom_addr    <= '0;
      pass            <= 1'b1;
      overrun         <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          cnt             <= '0;
          bus.rom_addr    <= '0;
          pass            <= 1'b1;
          overrun         <= 1'b0;
          err_count       <= '0;
          first_fail_addr <= '0;
        end
        S_FETCH: begin
          if (fetchLast) begin
            cnt <= '0;
            // end vector fields are don't-care; keep last operands on the bus
            if (!romEnd) begin
              mutReg     <= bus.rom_data[0];
              expBoolReg <= bus.rom_data[1];
              opReg      <= bus.rom_data[VEC_W-1:8];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WAIT: cnt <= waitLast ? 4'd0 : cnt + 4'd1;
        S_CHECK: begin
          if (mismatch) begin
            pass <= 1'b0;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (err_count == '0) first_fail_addr <= bus.rom_addr;
          end
          if (!stopNow) begin
            if (addrWrap) begin
              overrun <= 1'b1;
              pass    <= 1'b0;
            end else begin
              bus.rom_addr <= addrSum[ADDR_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_esfa_vector_sequencer.sv
// Bench for esfa_vector_sequencer: three instances (defaults, long latencies
// with 16-bit fields, 4-bit address space), ROM/DUT models, issue scoreboard.
module tb_esfa_vector_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stopOnFail, startA, startB, startC;
  int tests = 0;
  int fails = 0;

  // ---------------- instance A: default parameters ----------------
  esfa_vector_sequencer_if #(.VAL_W(8), .ADDR_W(32)) ifA();
  logic busyA, doneA, passA, ovrA;
  logic [15:0] errA;
  logic [31:0] ffaA;
  esfa_vector_sequencer uA (
    .clk(clk), .reset(reset), .start(startA), .stop_on_fail(stopOnFail), .bus(ifA),
    .busy(busyA), .done(doneA), .pass(passA), .overrun(ovrA),
    .err_count(errA), .first_fail_addr(ffaA)
  );
  logic [47:0] memA [16];
  assign ifA.rom_data         = (ifA.rom_addr < 32'd128) ? memA[ifA.rom_addr[6:3]] : '0;
  assign ifA.dut_result_value = ifA.dut_value;
  assign ifA.dut_result_bool  = ifA.dut_selector[0];

  // ---------------- instance B: ROM_LAT=3, DUT_LAT=4, VAL_W=16 ----------------
  esfa_vector_sequencer_if #(.VAL_W(16), .ADDR_W(32)) ifB();
  logic busyB, doneB, passB, ovrB;
  logic [15:0] errB;
  logic [31:0] ffaB, addrB1, addrB2;
  esfa_vector_sequencer #(.VAL_W(16), .ROM_LAT(3), .DUT_LAT(4)) uB (
    .clk(clk), .reset(reset), .start(startB), .stop_on_fail(stopOnFail), .bus(ifB),
    .busy(busyB), .done(doneB), .pass(passB), .overrun(ovrB),
    .err_count(errB), .first_fail_addr(ffaB)
  );
  logic [87:0] memB [16];
  always @(posedge clk) begin
    addrB1 <= ifB.rom_addr;
    addrB2 <= addrB1;
  end
  assign ifB.rom_data         = memB[addrB2[6:3]];
  assign ifB.dut_result_value = ifB.dut_value;
  assign ifB.dut_result_bool  = ifB.dut_selector[0];

  // ---------------- instance C: ADDR_W=4 ----------------
  esfa_vector_sequencer_if #(.VAL_W(8), .ADDR_W(4)) ifC();
  logic busyC, doneC, passC, ovrC;
  logic [15:0] errC;
  logic [3:0] ffaC;
  esfa_vector_sequencer #(.ADDR_W(4)) uC (
    .clk(clk), .reset(reset), .start(startC), .stop_on_fail(stopOnFail), .bus(ifC),
    .busy(busyC), .done(doneC), .pass(passC), .overrun(ovrC),
    .err_count(errC), .first_fail_addr(ffaC)
  );
  logic [47:0] memC [2];
  assign ifC.rom_data         = memC[ifC.rom_addr[3]];
  assign ifC.dut_result_value = ifC.dut_value;
  assign ifC.dut_result_bool  = ifC.dut_selector[0];

  // ---------------- vector builders ----------------
  function automatic logic [47:0] vec8(bit mut, bit eb, bit eop,
      logic [7:0] h, logic [7:0] i, logic [7:0] v, logic [7:0] s, logic [7:0] e);
    return {e, s, v, i, h, 5'b0, eop, eb, mut};
  endfunction

  function automatic logic [87:0] vec16(bit mut, bit eb, bit eop,
      logic [15:0] h, logic [15:0] i, logic [15:0] v, logic [15:0] s, logic [15:0] e);
    return {e, s, v, i, h, 5'b0, eop, eb, mut};
  endfunction

  // ---------------- scoreboard for instance A issues ----------------
  logic [63:0] qA[$];
  logic [63:0] expA;
  logic saw16A;
  always @(negedge clk) begin
    if (!reset && ifA.dut_valid) begin
      tests++;
      if (qA.size() == 0) begin
        fails++;
        $display("FAIL issueA_unexpected got addr=%0h want no issue", ifA.rom_addr);
      end else begin
        expA = qA.pop_front();
        if ({ifA.rom_addr, ifA.dut_handle, ifA.dut_index, ifA.dut_value, ifA.dut_selector} !== expA) begin
          fails++;
          $display("FAIL issueA got %h want %h",
                   {ifA.rom_addr, ifA.dut_handle, ifA.dut_index, ifA.dut_value, ifA.dut_selector}, expA);
        end
      end
    end
    if (busyA && ifA.rom_addr == 32'd16) saw16A = 1'b1;
  end

  task automatic clear_a();
    for (int k = 0; k < 16; k++) memA[k] = vec8(0, 0, 1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    qA.delete();
  endtask

  task automatic put_a(int idx, bit mut, bit eb, bit eop, logic [7:0] h, logic [7:0] i,
      logic [7:0] v, logic [7:0] s, logic [7:0] e, bit issues);
    memA[idx] = vec8(mut, eb, eop, h, i, v, s, e);
    if (issues) qA.push_back({32'(idx * 8), h, i, v, s});
  endtask

  // pulse start on A and count cycles until done; pokeAt re-pulses start mid-run
  task automatic run_a(input int pokeAt, output int n);
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    n = 0;
    while (!doneA && n < 200) begin
      startA = (n == pokeAt);
      @(posedge clk); #1;
      n++;
    end
    startA = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busyA !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busyA); end
    tests++; if (doneA !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", doneA); end
    tests++; if (passA !== 1'b1) begin fails++; $display("FAIL reset_pass got %b want 1", passA); end
    tests++; if ({ovrA, errA, ffaA, ifA.rom_addr} !== '0) begin
      fails++; $display("FAIL reset_status got %h want 0", {ovrA, errA, ffaA, ifA.rom_addr}); end
    tests++; if ({ifA.dut_valid, ifA.dut_handle, ifA.dut_index, ifA.dut_value, ifA.dut_selector} !== '0) begin
      fails++; $display("FAIL reset_dut got %h want 0",
        {ifA.dut_valid, ifA.dut_handle, ifA.dut_index, ifA.dut_value, ifA.dut_selector}); end
    reset = 1'b0;
  endtask

  task automatic test_all_pass();
    int n;
    clear_a();
    put_a(0, 0, 1, 0, 8'h11, 8'h22, 8'h33, 8'h01, 8'h33, 1);
    put_a(1, 0, 0, 0, 8'hA1, 8'hB2, 8'h44, 8'h02, 8'h44, 1);
    put_a(2, 0, 1, 0, 8'hC3, 8'hD4, 8'h66, 8'h05, 8'h66, 1);
    put_a(3, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    stopOnFail = 1'b0;
    run_a(-1, n);
    tests++; if (n !== 13) begin fails++; $display("FAIL allpass_cycles got %0d want 13", n); end
    tests++; if ({doneA, busyA, passA, ovrA} !== 4'b1010) begin
      fails++; $display("FAIL allpass_flags got %b want 1010", {doneA, busyA, passA, ovrA}); end
    tests++; if (errA !== 16'd0) begin fails++; $display("FAIL allpass_err got %0d want 0", errA); end
    tests++; if (qA.size() !== 0) begin fails++; $display("FAIL allpass_issues left %0d want 0", qA.size()); end
  endtask

  task automatic test_stop_on_fail();
    int n;
    clear_a();
    put_a(0, 0, 1, 0, 8'h01, 8'h02, 8'h10, 8'h01, 8'h10, 1);
    put_a(1, 0, 0, 0, 8'h03, 8'h04, 8'h5B, 8'h00, 8'h5A, 1);
    put_a(2, 0, 1, 0, 8'h05, 8'h06, 8'h20, 8'h01, 8'h20, 0);
    put_a(3, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    stopOnFail = 1'b1;
    saw16A = 1'b0;
    run_a(-1, n);
    tests++; if (n !== 8) begin fails++; $display("FAIL stop_cycles got %0d want 8", n); end
    tests++; if ({doneA, passA, ovrA} !== 3'b100) begin
      fails++; $display("FAIL stop_flags got %b want 100", {doneA, passA, ovrA}); end
    tests++; if (errA !== 16'd1) begin fails++; $display("FAIL stop_err got %0d want 1", errA); end
    tests++; if (ffaA !== 32'd8) begin fails++; $display("FAIL stop_ffa got %0h want 8", ffaA); end
    tests++; if (saw16A !== 1'b0) begin fails++; $display("FAIL stop_fetch16 got %b want 0", saw16A); end
    tests++; if (qA.size() !== 0) begin fails++; $display("FAIL stop_issues left %0d want 0", qA.size()); end
    stopOnFail = 1'b0;
  endtask

  task automatic test_continue();
    int n;
    clear_a();
    put_a(0, 0, 1, 0, 8'h01, 8'h02, 8'h10, 8'h01, 8'h10, 1);
    put_a(1, 0, 0, 0, 8'h03, 8'h04, 8'h5B, 8'h00, 8'h5A, 1);
    put_a(2, 0, 0, 0, 8'h05, 8'h06, 8'h20, 8'h01, 8'h20, 1);
    put_a(3, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    stopOnFail = 1'b0;
    run_a(5, n);  // start while busy must be ignored
    tests++; if (n !== 13) begin fails++; $display("FAIL cont_cycles got %0d want 13", n); end
    tests++; if (errA !== 16'd2) begin fails++; $display("FAIL cont_err got %0d want 2", errA); end
    tests++; if (ffaA !== 32'd8) begin fails++; $display("FAIL cont_ffa got %0h want 8", ffaA); end
    tests++; if ({doneA, passA, ovrA} !== 3'b100) begin
      fails++; $display("FAIL cont_flags got %b want 100", {doneA, passA, ovrA}); end
    tests++; if (qA.size() !== 0) begin fails++; $display("FAIL cont_issues left %0d want 0", qA.size()); end
  endtask

  task automatic test_mutating();
    int n;
    clear_a();
    put_a(0, 1, 0, 0, 8'h77, 8'h88, 8'h10, 8'h01, 8'h99, 1);
    put_a(1, 0, 1, 0, 8'h12, 8'h34, 8'h56, 8'h03, 8'h56, 1);
    put_a(2, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    run_a(-1, n);  // restarts from DONE of the previous failing run
    tests++; if (n !== 9) begin fails++; $display("FAIL mut_cycles got %0d want 9", n); end
    tests++; if ({passA, errA, ffaA} !== {1'b1, 16'd0, 32'd0}) begin
      fails++; $display("FAIL mut_result got pass=%b err=%0d ffa=%0h want pass=1 err=0 ffa=0", passA, errA, ffaA); end
    tests++; if (qA.size() !== 0) begin fails++; $display("FAIL mut_issues left %0d want 0", qA.size()); end
  endtask

  task automatic test_reset_mid_run();
    int k, v, n;
    clear_a();
    put_a(0, 0, 1, 0, 8'h01, 8'h02, 8'h10, 8'h01, 8'h11, 1);  // mismatch
    put_a(1, 0, 0, 0, 8'h03, 8'h04, 8'h20, 8'h00, 8'h20, 1);
    put_a(2, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    k = 0; v = 0;
    while (v < 2 && k < 50) begin
      @(posedge clk); #1;
      k++;
      if (ifA.dut_valid) v++;
    end
    tests++; if (v !== 2) begin fails++; $display("FAIL rst_issue_timeout got %0d issues want 2", v); end
    @(posedge clk); #1;  // now in WAIT of the vector at addr 8
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if ({busyA, doneA, passA, ovrA} !== 4'b0010) begin
      fails++; $display("FAIL rst_flags got %b want 0010", {busyA, doneA, passA, ovrA}); end
    tests++; if ({errA, ffaA, ifA.rom_addr} !== '0) begin
      fails++; $display("FAIL rst_status got %h want 0", {errA, ffaA, ifA.rom_addr}); end
    tests++; if ({ifA.dut_valid, ifA.dut_handle, ifA.dut_index, ifA.dut_value, ifA.dut_selector} !== '0) begin
      fails++; $display("FAIL rst_dut got %h want 0",
        {ifA.dut_valid, ifA.dut_handle, ifA.dut_index, ifA.dut_value, ifA.dut_selector}); end
    reset = 1'b0;
    clear_a();
    put_a(0, 0, 1, 0, 8'h21, 8'h22, 8'h23, 8'h01, 8'h23, 1);
    put_a(1, 0, 0, 0, 8'h31, 8'h32, 8'h33, 8'h00, 8'h33, 1);
    put_a(2, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    run_a(-1, n);
    tests++; if (n !== 9) begin fails++; $display("FAIL rerun_cycles got %0d want 9", n); end
    tests++; if ({passA, errA} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL rerun_result got pass=%b err=%0d want pass=1 err=0", passA, errA); end
    tests++; if (qA.size() !== 0) begin fails++; $display("FAIL rerun_issues left %0d want 0", qA.size()); end
  endtask

  task automatic test_latency();
    logic [63:0] qB[$];
    logic [63:0] snap, expB;
    int n, prev, valids, holdLeft, unstable;
    for (int k = 0; k < 16; k++) memB[k] = vec16(0, 0, 1, '0, '0, '0, '0, '0);
    memB[0] = vec16(0, 1, 0, 16'h1111, 16'h2222, 16'h3333, 16'h0001, 16'h3333);
    memB[1] = vec16(0, 0, 0, 16'hABCD, 16'hBCDE, 16'hCDEF, 16'h0010, 16'hCDEF);
    memB[2] = vec16(0, 1, 0, 16'hF00D, 16'hBEEF, 16'h0F0F, 16'h8001, 16'h0F0F);
    qB.push_back({16'h1111, 16'h2222, 16'h3333, 16'h0001});
    qB.push_back({16'hABCD, 16'hBCDE, 16'hCDEF, 16'h0010});
    qB.push_back({16'hF00D, 16'hBEEF, 16'h0F0F, 16'h8001});
    startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    n = 0; prev = -1; valids = 0; holdLeft = 0; unstable = 0; snap = '0;
    while (!doneB && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (ifB.dut_valid) begin
        snap = {ifB.dut_handle, ifB.dut_index, ifB.dut_value, ifB.dut_selector};
        if (prev >= 0) begin
          tests++;
          if (n - prev !== 9) begin fails++; $display("FAIL lat_spacing got %0d want 9", n - prev); end
        end
        tests++;
        expB = (qB.size() != 0) ? qB.pop_front() : '1;
        if (snap !== expB) begin fails++; $display("FAIL lat_operands got %h want %h", snap, expB); end
        prev = n; valids++; holdLeft = 5;
      end else if (holdLeft > 0) begin
        if ({ifB.dut_handle, ifB.dut_index, ifB.dut_value, ifB.dut_selector} !== snap) unstable++;
        holdLeft--;
      end
    end
    tests++; if (valids !== 3) begin fails++; $display("FAIL lat_issues got %0d want 3", valids); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL lat_stable got %0d changes want 0", unstable); end
    tests++; if (n !== 30) begin fails++; $display("FAIL lat_cycles got %0d want 30", n); end
    tests++; if ({passB, errB} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL lat_result got pass=%b err=%0d want pass=1 err=0", passB, errB); end
  endtask

  task automatic test_overrun();
    int n, valids;
    memC[0] = vec8(0, 1, 0, 8'h01, 8'h02, 8'h03, 8'h01, 8'h03);
    memC[1] = vec8(0, 0, 0, 8'h04, 8'h05, 8'h06, 8'h00, 8'h06);
    startC = 1'b1;
    @(posedge clk); #1;
    startC = 1'b0;
    n = 0; valids = 0;
    while (!doneC && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (ifC.dut_valid) valids++;
    end
    tests++; if (n !== 8) begin fails++; $display("FAIL ovr_cycles got %0d want 8", n); end
    tests++; if ({ovrC, passC} !== 2'b10) begin
      fails++; $display("FAIL ovr_flags got ovr=%b pass=%b want ovr=1 pass=0", ovrC, passC); end
    tests++; if (errC !== 16'd0) begin fails++; $display("FAIL ovr_err got %0d want 0", errC); end
    tests++; if (valids !== 2) begin fails++; $display("FAIL ovr_issues got %0d want 2", valids); end
    tests++; if (ifC.rom_addr !== 4'd8) begin fails++; $display("FAIL ovr_addr got %0h want 8", ifC.rom_addr); end
  endtask

  initial begin
    reset = 1'b1; stopOnFail = 1'b0;
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    saw16A = 1'b0;
    for (int k = 0; k < 16; k++) memB[k] = '0;
    memC[0] = '0; memC[1] = '0;
    clear_a();
    test_reset();
    test_all_pass();
    test_stop_on_fail();
    test_continue();
    test_mutating();
    test_reset_mid_run();
    test_latency();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
